operand_capture: RTL and testbench

//  Collects NUM_OPS operands of DIGITS_PER_OP keypad digits each, entered most-significant digit first.

---
 rtl/keypad_pkg.sv | 16 +
 rtl/key_edge.sv | 18 +
 rtl/operand_capture.sv | 135 +++++++++++++
 tb/tb_operand_capture.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: capture FSM states, default control key codes
// and a digit classifier used by keypad consumers.
package keypad_pkg;

   typedef enum logic {ENTRY, READY} cap_state_t;

   localparam logic [3:0] KEY_ENTER_DEF = 4'hF;
   localparam logic [3:0] KEY_BKSP_DEF  = 4'hE;

   function automatic logic is_digit(input logic [31:0] code,
                                     input logic [31:0] enter,
                                     input logic [31:0] bksp);
      return (code != enter) && (code != bksp);
   endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for a debounced key level; a held key yields one pulse.
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic kp_q;

   always_ff @(posedge clk) begin
      if (rst) kp_q <= 1'b0;
      else     kp_q <= level;
   end

   assign rise = level & ~kp_q;

endmodule

// File: rtl/operand_capture.sv
// Collects NUM_OPS keypad operands (MSD first) with backspace/enter/auto-advance
// and hands them to the multiplier control through a listo/ack handshake.
module operand_capture
   import keypad_pkg::*;
#(
   parameter int DIGIT_W                  = 4,
   parameter int DIGITS_PER_OP            = 2,
   parameter int NUM_OPS                  = 2,
   parameter int AUTO_ADV                 = 1,
   parameter logic [DIGIT_W-1:0] KEY_ENTER = DIGIT_W'(KEY_ENTER_DEF),
   parameter logic [DIGIT_W-1:0] KEY_BKSP  = DIGIT_W'(KEY_BKSP_DEF)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   key_pressed,
   input  logic [DIGIT_W-1:0]                     key_value,
   input  logic                                   ack,
   output logic [NUM_OPS*DIGIT_W*DIGITS_PER_OP-1:0] ops,
   output logic [$clog2(NUM_OPS):0]               op_idx,
   output logic [$clog2(DIGITS_PER_OP):0]         digit_cnt,
   output logic                                   listo,
   output logic                                   err
);

   localparam int OP_W  = DIGIT_W * DIGITS_PER_OP;
   localparam int IDX_W = $clog2(NUM_OPS) + 1;
   localparam int CNT_W = $clog2(DIGITS_PER_OP) + 1;

   cap_state_t          state, state_nx;
   logic [OP_W-1:0]     op    [NUM_OPS];
   logic [OP_W-1:0]     op_nx [NUM_OPS];
   logic [IDX_W-1:0]    idx, idx_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                err_q, err_nx;
   logic                key_rise;
   logic                advance;
   logic [OP_W-1:0]     cur, cur_nx;

   key_edge u_key_edge (
      .clk   (clk),
      .rst   (rst),
      .level (key_pressed),
      .rise  (key_rise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ENTRY;
         idx   <= '0;
         cnt   <= '0;
         err_q <= 1'b0;
         for (int unsigned k = 0; k < NUM_OPS; k++) op[k] <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
         err_q <= err_nx;
         op    <= op_nx;
      end
   end

   // The operand under edit is pulled into cur, modified, then written back
   // by index, so the array is never indexed with the wider idx vector.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      err_nx   = 1'b0;
      op_nx    = op;
      advance  = 1'b0;
      cur      = '0;
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
         if (idx == IDX_W'(k)) cur = op[k];
      end
      cur_nx = cur;

      unique case (state)
         ENTRY: begin
            if (key_rise) begin
               if (is_digit(32'(key_value), 32'(KEY_ENTER), 32'(KEY_BKSP))) begin
                  if (cnt < CNT_W'(DIGITS_PER_OP)) begin
                     cur_nx  = (cur << DIGIT_W) | OP_W'(key_value);
                     cnt_nx  = cnt + CNT_W'(1);
                     advance = (AUTO_ADV != 0) && (cnt_nx == CNT_W'(DIGITS_PER_OP));
                  end else begin
                     err_nx = 1'b1;
                  end
               end else if (key_value == KEY_BKSP) begin
                  if (cnt != '0) begin
                     cur_nx = cur >> DIGIT_W;
                     cnt_nx = cnt - CNT_W'(1);
                  end else begin
                     err_nx = 1'b1;
                  end
               end else begin
                  advance = 1'b1;
               end

               // Final advance keeps the count so the last operand stays visible in READY
               if (advance) begin
                  if (idx < IDX_W'(NUM_OPS - 1)) begin
                     idx_nx = idx + IDX_W'(1);
                     cnt_nx = '0;
                  end else begin
                     state_nx = READY;
                  end
               end
            end
            for (int unsigned k = 0; k < NUM_OPS; k++) begin
               if (idx == IDX_W'(k)) op_nx[k] = cur_nx;
            end
         end
         READY: begin
            if (ack) begin
               state_nx = ENTRY;
               idx_nx   = '0;
               cnt_nx   = '0;
               for (int unsigned k = 0; k < NUM_OPS; k++) op_nx[k] = '0;
            end else if (key_rise) begin
               err_nx = 1'b1;
            end
         end
      endcase
   end

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_pack
      assign ops[g*OP_W +: OP_W] = op[g];
   end

   assign op_idx    = idx;
   assign digit_cnt = cnt;
   assign listo     = (state == READY);
   assign err       = err_q;

endmodule

// File: tb/tb_operand_capture.sv
// Bench for operand_capture: three configurations checked against a digit-list model.
module tb_operand_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        kp  [3];
   logic [3:0]  kv  [3];
   logic        ack [3];

   logic [15:0] ops_a, ops_b;
   logic [47:0] ops_c;
   logic [1:0]  idx_a, idx_b, cnt_a, cnt_b;
   logic [2:0]  idx_c, cnt_c;
   logic        listo_a, listo_b, listo_c, err_a, err_b, err_c;

   logic [63:0] o_ops   [3];
   logic [3:0]  o_idx   [3];
   logic [3:0]  o_cnt   [3];
   logic        o_listo [3];
   logic        o_err   [3];

   int checks = 0;
   int errors = 0;

   // model: digits held per unit/operand, in entry order
   int m_d     [3][3][4];
   int m_n     [3][3];
   int m_idx   [3];
   bit m_ready [3];

   always #5 clk = ~clk;

   operand_capture #(.DIGIT_W(4), .DIGITS_PER_OP(2), .NUM_OPS(2), .AUTO_ADV(0)) dut_a (
      .clk(clk), .rst(rst), .key_pressed(kp[0]), .key_value(kv[0]), .ack(ack[0]),
      .ops(ops_a), .op_idx(idx_a), .digit_cnt(cnt_a), .listo(listo_a), .err(err_a));

   operand_capture #(.DIGIT_W(4), .DIGITS_PER_OP(2), .NUM_OPS(2), .AUTO_ADV(1)) dut_b (
      .clk(clk), .rst(rst), .key_pressed(kp[1]), .key_value(kv[1]), .ack(ack[1]),
      .ops(ops_b), .op_idx(idx_b), .digit_cnt(cnt_b), .listo(listo_b), .err(err_b));

   operand_capture #(.DIGIT_W(4), .DIGITS_PER_OP(4), .NUM_OPS(3), .AUTO_ADV(0)) dut_c (
      .clk(clk), .rst(rst), .key_pressed(kp[2]), .key_value(kv[2]), .ack(ack[2]),
      .ops(ops_c), .op_idx(idx_c), .digit_cnt(cnt_c), .listo(listo_c), .err(err_c));

   assign o_ops[0]   = {48'b0, ops_a};
   assign o_ops[1]   = {48'b0, ops_b};
   assign o_ops[2]   = {16'b0, ops_c};
   assign o_idx[0]   = {2'b0, idx_a};
   assign o_idx[1]   = {2'b0, idx_b};
   assign o_idx[2]   = {1'b0, idx_c};
   assign o_cnt[0]   = {2'b0, cnt_a};
   assign o_cnt[1]   = {2'b0, cnt_b};
   assign o_cnt[2]   = {1'b0, cnt_c};
   assign o_listo[0] = listo_a;
   assign o_listo[1] = listo_b;
   assign o_listo[2] = listo_c;
   assign o_err[0]   = err_a;
   assign o_err[1]   = err_b;
   assign o_err[2]   = err_c;

   function automatic int nops(input int u);
      return (u == 2) ? 3 : 2;
   endfunction

   function automatic int ndig(input int u);
      return (u == 2) ? 4 : 2;
   endfunction

   function automatic bit auto_adv(input int u);
      return (u == 1);
   endfunction

   function automatic void model_clear(input int u);
      m_ready[u] = 1'b0;
      m_idx[u]   = 0;
      for (int k = 0; k < 3; k++) m_n[u][k] = 0;
   endfunction

   function automatic void model_advance(input int u);
      if (m_idx[u] < nops(u) - 1) m_idx[u]++;
      else m_ready[u] = 1'b1;
   endfunction

   // returns the expected err pulse for a key edge
   function automatic logic model_key(input int u, input int code);
      int i;
      if (m_ready[u]) return 1'b1;
      i = m_idx[u];
      if (code == 15) begin
         model_advance(u);
      end else if (code == 14) begin
         if (m_n[u][i] == 0) return 1'b1;
         m_n[u][i]--;
      end else begin
         if (m_n[u][i] == ndig(u)) return 1'b1;
         m_d[u][i][m_n[u][i]] = code;
         m_n[u][i]++;
         if (auto_adv(u) && m_n[u][i] == ndig(u)) model_advance(u);
      end
      return 1'b0;
   endfunction

   function automatic logic [63:0] exp_ops(input int u);
      longint unsigned v, val;
      v = 0;
      for (int k = 0; k < nops(u); k++) begin
         val = 0;
         for (int j = 0; j < m_n[u][k]; j++) val = val * 16 + longint'(m_d[u][k][j]);
         v = v + val * (longint'(1) << (k * 4 * ndig(u)));
      end
      return v;
   endfunction

   task automatic press(input int u, input logic [3:0] code, input int hold);
      logic        e;
      logic [63:0] eo;
      e = model_key(u, int'(code));
      eo = exp_ops(u);
      kv[u] = code;
      kp[u] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_err[u] !== e) begin
         errors++; $display("FAIL key_err u=%0d key=%h got=%b exp=%b", u, code, o_err[u], e);
      end
      checks++;
      if (o_ops[u] !== eo) begin
         errors++; $display("FAIL key_ops u=%0d key=%h got=%h exp=%h", u, code, o_ops[u], eo);
      end
      checks++;
      if (o_idx[u] !== 4'(m_idx[u])) begin
         errors++; $display("FAIL key_idx u=%0d key=%h got=%0d exp=%0d", u, code, o_idx[u], m_idx[u]);
      end
      checks++;
      if (o_cnt[u] !== 4'(m_n[u][m_idx[u]])) begin
         errors++; $display("FAIL key_cnt u=%0d key=%h got=%0d exp=%0d", u, code, o_cnt[u], m_n[u][m_idx[u]]);
      end
      checks++;
      if (o_listo[u] !== m_ready[u]) begin
         errors++; $display("FAIL key_listo u=%0d key=%h got=%b exp=%b", u, code, o_listo[u], m_ready[u]);
      end
      repeat (hold) begin
         @(posedge clk); #1;
         checks++;
         if (o_err[u] !== 1'b0) begin
            errors++; $display("FAIL err_width u=%0d got=%b exp=0", u, o_err[u]);
         end
      end
      checks++;
      if (o_ops[u] !== eo) begin
         errors++; $display("FAIL held_ops u=%0d got=%h exp=%h", u, o_ops[u], eo);
      end
      kp[u] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_ack(input int u, input bit with_key, input logic [3:0] code);
      logic e;
      if (m_ready[u]) begin
         model_clear(u);
         e = 1'b0;
      end else begin
         e = with_key ? model_key(u, int'(code)) : 1'b0;
      end
      ack[u] = 1'b1;
      if (with_key) begin
         kv[u] = code;
         kp[u] = 1'b1;
      end
      @(posedge clk); #1;
      ack[u] = 1'b0;
      checks++;
      if (o_err[u] !== e) begin
         errors++; $display("FAIL ack_err u=%0d got=%b exp=%b", u, o_err[u], e);
      end
      checks++;
      if (o_ops[u] !== exp_ops(u)) begin
         errors++; $display("FAIL ack_ops u=%0d got=%h exp=%h", u, o_ops[u], exp_ops(u));
      end
      checks++;
      if (o_listo[u] !== m_ready[u] || o_idx[u] !== 4'(m_idx[u])) begin
         errors++; $display("FAIL ack_state u=%0d got listo=%b idx=%0d exp listo=%b idx=%0d",
                            u, o_listo[u], o_idx[u], m_ready[u], m_idx[u]);
      end
      checks++;
      if (o_cnt[u] !== 4'(m_n[u][m_idx[u]])) begin
         errors++; $display("FAIL ack_cnt u=%0d got=%0d exp=%0d", u, o_cnt[u], m_n[u][m_idx[u]]);
      end
      kp[u] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int u = 0; u < 3; u++) begin
         kp[u] = 1'b0; ack[u] = 1'b0; kv[u] = 4'h0;
         model_clear(u);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (o_ops[u] !== 64'h0 || o_idx[u] !== 4'h0 || o_cnt[u] !== 4'h0 ||
             o_listo[u] !== 1'b0 || o_err[u] !== 1'b0) begin
            errors++; $display("FAIL reset_state u=%0d got ops=%h idx=%0d cnt=%0d listo=%b err=%b exp all 0",
                               u, o_ops[u], o_idx[u], o_cnt[u], o_listo[u], o_err[u]);
         end
      end
   endtask

   task automatic test_basic_entry();
      logic [3:0] seq [6];
      seq = '{4'h3, 4'h7, 4'hF, 4'h1, 4'h2, 4'hF};
      do_reset();
      foreach (seq[i]) press(0, seq[i], 1);
      checks++;
      if (ops_a !== 16'h1237 || listo_a !== 1'b1) begin
         errors++; $display("FAIL basic_ops got=%h listo=%b exp=1237 listo=1", ops_a, listo_a);
      end
   endtask

   task automatic test_auto_advance();
      do_reset();
      press(1, 4'hA, 1);
      checks++;
      if (idx_b !== 2'd0) begin
         errors++; $display("FAIL auto_idx_a got=%0d exp=0", idx_b);
      end
      press(1, 4'hB, 1);
      checks++;
      if (idx_b !== 2'd1) begin
         errors++; $display("FAIL auto_idx_b got=%0d exp=1", idx_b);
      end
      press(1, 4'hC, 1);
      press(1, 4'hD, 1);
      checks++;
      if (ops_b !== 16'hCDAB || listo_b !== 1'b1) begin
         errors++; $display("FAIL auto_ops got=%h listo=%b exp=cdab listo=1", ops_b, listo_b);
      end
   endtask

   task automatic test_backspace();
      logic [3:0] seq [6];
      seq = '{4'h5, 4'hE, 4'hE, 4'h9, 4'hF, 4'hF};
      do_reset();
      foreach (seq[i]) press(0, seq[i], 1);
      checks++;
      if (ops_a !== 16'h0009 || listo_a !== 1'b1) begin
         errors++; $display("FAIL bksp_ops got=%h listo=%b exp=0009 listo=1", ops_a, listo_a);
      end
   endtask

   task automatic test_held_key();
      do_reset();
      press(0, 4'h4, 20);
      checks++;
      if (ops_a[7:0] !== 8'h04 || cnt_a !== 2'd1) begin
         errors++; $display("FAIL held_key got op0=%h cnt=%0d exp op0=04 cnt=1", ops_a[7:0], cnt_a);
      end
   endtask

   task automatic test_ready_handshake();
      do_reset();
      press(0, 4'h1, 1);
      press(0, 4'hF, 1);
      press(0, 4'h2, 1);
      press(0, 4'hF, 1);
      press(0, 4'h6, 1);
      checks++;
      if (ops_a !== 16'h0201 || listo_a !== 1'b1) begin
         errors++; $display("FAIL ready_frozen got=%h listo=%b exp=0201 listo=1", ops_a, listo_a);
      end
      do_ack(0, 1'b1, 4'h3);
      checks++;
      if (ops_a !== 16'h0 || listo_a !== 1'b0 || idx_a !== 2'd0) begin
         errors++; $display("FAIL ack_clear got ops=%h listo=%b idx=%0d exp 0", ops_a, listo_a, idx_a);
      end
      do_ack(0, 1'b0, 4'h0);
   endtask

   task automatic test_reset_mid_entry();
      do_reset();
      press(2, 4'h1, 1);
      press(2, 4'h2, 1);
      press(2, 4'h3, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear(2);
      checks++;
      if (ops_c !== 48'h0 || idx_c !== 3'd0 || cnt_c !== 3'd0 || listo_c !== 1'b0 || err_c !== 1'b0) begin
         errors++; $display("FAIL midreset got ops=%h idx=%0d cnt=%0d listo=%b err=%b exp all 0",
                            ops_c, idx_c, cnt_c, listo_c, err_c);
      end
   endtask

   task automatic test_wide_config();
      logic [3:0] seq [7];
      seq = '{4'h3, 4'h7, 4'hF, 4'h1, 4'h2, 4'hF, 4'hF};
      do_reset();
      foreach (seq[i]) press(2, seq[i], 1);
      checks++;
      if (ops_c !== 48'h0000_0012_0037 || listo_c !== 1'b1) begin
         errors++; $display("FAIL wide_ops got=%h listo=%b exp=000000120037 listo=1", ops_c, listo_c);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int u = 0; u < 3; u++) begin
         for (int n = 0; n < 300; n++) begin
            if (m_ready[u] && $urandom_range(0, 2) != 0)
               do_ack(u, bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            else if ($urandom_range(0, 19) == 0)
               do_ack(u, 1'b0, 4'h0);
            else
               press(u, 4'($urandom_range(0, 15)), $urandom_range(1, 3));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int u = 0; u < 3; u++) begin
         kp[u] = 1'b0; ack[u] = 1'b0; kv[u] = 4'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_basic_entry();
      test_auto_advance();
      test_backspace();
      test_held_key();
      test_ready_handshake();
      test_reset_mid_entry();
      test_wide_config();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
